// File: rtl/ysyx_041514_alu_mul_csa_pipe_if.sv
// Handshake bundle between the Booth partial-product generator, the CSA
// reduction pipe and the EXU result mux. master = surrounding logic, slave = pipe.
interface ysyx_041514_alu_mul_csa_pipe_if;
  logic           valid_i;
  logic           ready_o;
  logic [4223:0]  pp_flat_i;
  logic           hi_sel_i;
  logic           word_sel_i;
  logic           valid_o;
  logic           ready_i;
  logic [63:0]    result_o;
  logic [127:0]   product_o;

  modport master (
    output valid_i, pp_flat_i, hi_sel_i, word_sel_i, ready_i,
    input  ready_o, valid_o, result_o, product_o
  );

  modport slave (
    input  valid_i, pp_flat_i, hi_sel_i, word_sel_i, ready_i,
    output ready_o, valid_o, result_o, product_o
  );
endinterface

// File: rtl/ysyx_041514_alu_mul_csa_pipe.sv
// Three-stage carry-save reduction of 33 radix-4 Booth partial products into a
// 128-bit product, with RISC-V MUL/MULH*/MULW result selection and elastic handshakes.
module ysyx_041514_alu_mul_csa_pipe #(
  parameter int unsigned PP_NUM = 33,
  parameter int unsigned PP_W   = 128
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush_i,
  ysyx_041514_alu_mul_csa_pipe_if.slave     bus
);

  localparam int unsigned S1Out = 7;
  localparam int unsigned S1Rows [5] = '{33, 22, 15, 10, 7};
  localparam int unsigned S2Rows [5] = '{7, 5, 4, 3, 2};

  function automatic logic [PP_W-1:0] csa_s(logic [PP_W-1:0] a, logic [PP_W-1:0] b,
                                            logic [PP_W-1:0] c);
    return a ^ b ^ c;
  endfunction

  function automatic logic [PP_W-1:0] csa_c(logic [PP_W-1:0] a, logic [PP_W-1:0] b,
                                            logic [PP_W-1:0] c);
    return ((a & b) | (a & c) | (b & c)) << 1;
  endfunction

  logic              r_v1, r_v2, r_v3;
  logic              r_s1_hi, r_s1_word, r_s2_hi, r_s2_word;
  logic [PP_W-1:0]   r_s1_row [S1Out];
  logic [PP_W-1:0]   r_s2_sum, r_s2_carry;
  logic [PP_W-1:0]   r_product;
  logic [63:0]       r_result;

  logic              w_adv1, w_adv2, w_adv3, w_ready, w_acc;
  logic [PP_W-1:0]   w_ext [PP_NUM];
  logic [PP_W-1:0]   w_t1 [5][PP_NUM];
  logic [PP_W-1:0]   w_t2 [5][S1Out];
  logic [PP_W-1:0]   w_sum;
  logic [63:0]       w_res;

  assign w_adv3  = r_v3 & bus.ready_i;
  assign w_adv2  = r_v2 & (~r_v3 | w_adv3);
  assign w_adv1  = r_v1 & (~r_v2 | w_adv2);
  assign w_ready = ~flush_i & (~r_v1 | w_adv1);
  assign w_acc   = bus.valid_i & w_ready;

  // pp k (k<32) is a 66-bit value at [2k+65:2k]; replicate its sign to the top.
  for (genvar k = 0; k < PP_NUM - 1; k++) begin : g_sext
    localparam int unsigned Top = 2 * k + 66;
    logic [PP_W-1:0] w_pp;
    assign w_pp     = bus.pp_flat_i[PP_W*k +: PP_W];
    assign w_ext[k] = w_pp | ({PP_W{w_pp[Top-1]}} << Top);
  end
  assign w_ext[PP_NUM-1] = bus.pp_flat_i[PP_W*(PP_NUM-1) +: PP_W];

  // Each layer compresses rows in groups of three; leftovers pass straight through.
  always_comb begin
    w_t1 = '{default: '0};
    for (int unsigned k = 0; k < PP_NUM; k++) w_t1[0][k] = w_ext[k];
    for (int unsigned l = 0; l < 4; l++) begin
      for (int unsigned i = 0; i < PP_NUM / 3; i++) begin
        if (i < S1Rows[l] / 3) begin
          w_t1[l+1][2*i]   = csa_s(w_t1[l][3*i], w_t1[l][3*i+1], w_t1[l][3*i+2]);
          w_t1[l+1][2*i+1] = csa_c(w_t1[l][3*i], w_t1[l][3*i+1], w_t1[l][3*i+2]);
        end
      end
      for (int unsigned r = 0; r < 2; r++) begin
        if (3 * (S1Rows[l] / 3) + r < S1Rows[l]) begin
          w_t1[l+1][2*(S1Rows[l]/3)+r] = w_t1[l][3*(S1Rows[l]/3)+r];
        end
      end
    end
  end

  always_comb begin
    w_t2 = '{default: '0};
    for (int unsigned k = 0; k < S1Out; k++) w_t2[0][k] = r_s1_row[k];
    for (int unsigned l = 0; l < 4; l++) begin
      for (int unsigned i = 0; i < S1Out / 3; i++) begin
        if (i < S2Rows[l] / 3) begin
          w_t2[l+1][2*i]   = csa_s(w_t2[l][3*i], w_t2[l][3*i+1], w_t2[l][3*i+2]);
          w_t2[l+1][2*i+1] = csa_c(w_t2[l][3*i], w_t2[l][3*i+1], w_t2[l][3*i+2]);
        end
      end
      for (int unsigned r = 0; r < 2; r++) begin
        if (3 * (S2Rows[l] / 3) + r < S2Rows[l]) begin
          w_t2[l+1][2*(S2Rows[l]/3)+r] = w_t2[l][3*(S2Rows[l]/3)+r];
        end
      end
    end
  end

  always_comb begin
    w_sum = r_s2_sum + r_s2_carry;
    w_res = w_sum[63:0];
    if (r_s2_word)    w_res = {{32{w_sum[31]}}, w_sum[31:0]};
    else if (r_s2_hi) w_res = w_sum[127:64];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_s1_hi    <= 1'b0;
      r_s1_word  <= 1'b0;
      r_s2_hi    <= 1'b0;
      r_s2_word  <= 1'b0;
      r_s2_sum   <= '0;
      r_s2_carry <= '0;
      r_product  <= '0;
      r_result   <= '0;
      for (int unsigned k = 0; k < S1Out; k++) r_s1_row[k] <= '0;
    end else begin
      if (flush_i) begin
        r_v1 <= 1'b0;
        r_v2 <= 1'b0;
        r_v3 <= 1'b0;
      end else begin
        if (~r_v1 | w_adv1) r_v1 <= bus.valid_i;
        if (~r_v2 | w_adv2) r_v2 <= r_v1;
        if (~r_v3 | w_adv3) r_v3 <= r_v2;
      end
      // Data only moves with an accepted/advancing op, so stalled or X inputs never leak in.
      if (w_acc) begin
        for (int unsigned k = 0; k < S1Out; k++) r_s1_row[k] <= w_t1[4][k];
        r_s1_hi   <= bus.hi_sel_i;
        r_s1_word <= bus.word_sel_i;
      end
      if (w_adv1) begin
        r_s2_sum   <= w_t2[4][0];
        r_s2_carry <= w_t2[4][1];
        r_s2_hi    <= r_s1_hi;
        r_s2_word  <= r_s1_word;
      end
      if (w_adv2) begin
        r_product <= w_sum;
        r_result  <= w_res;
      end
    end
  end

  assign bus.ready_o   = w_ready;
  assign bus.valid_o   = r_v3;
  assign bus.result_o  = r_result;
  assign bus.product_o = r_product;

endmodule
